// File: rtl/rev_gate_sequencer.sv
// Reversible gate sequencer: runs a stored program of self-inverse gates
// over a 4-bit working register, forward to compute or reverse to uncompute.
module rev_gate_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic          len_we,
  input  logic [AW:0]   len_data,
  input  logic          dir,
  input  logic          in_valid,
  input  logic [3:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [3:0]    out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [3:0]    r_q, r_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic          dir_q, dir_d;
  logic          err_q, err_d;
  logic [7:0]    mem_q [DEPTH];

  logic [7:0]    ent;
  logic [1:0]    g_op, g_t, g_a, g_b;
  logic [3:0]    g_r;
  logic          g_ill;

  assign ent  = mem_q[ptr_q];
  assign g_op = ent[7:6];
  assign g_t  = ent[5:4];
  assign g_a  = ent[3:2];
  assign g_b  = ent[1:0];

  always_comb begin
    g_r   = r_q;
    g_ill = 1'b0;
    unique case (g_op)
      2'b00: g_r[g_t] = ~r_q[g_t];
      2'b01: begin
        if (g_t == g_a) g_ill = 1'b1;
        else g_r[g_t] = r_q[g_t] ^ r_q[g_a];
      end
      2'b10: begin
        if (g_t == g_a || g_t == g_b || g_a == g_b)
          g_ill = 1'b1;
        else
          g_r[g_t] = r_q[g_t] ^ (r_q[g_a] & r_q[g_b]);
      end
      default: begin
        // fan-out: every bit except the control toggles
        g_r = r_q ^ ({4{r_q[g_a]}} &
                     (4'b1111 ^ (4'b0001 << g_a)));
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    dir_d   = dir_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (len_we)
          len_d = (len_data > DEPTH_L) ? DEPTH_L : len_data;
        if (in_valid) begin
          r_d   = in_data;
          dir_d = dir;
          err_d = 1'b0;
          cnt_d = len_q;
          ptr_d = dir ? (len_q[AW-1:0] - 1'b1) : '0;
          state_d = (len_q != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        r_d   = g_r;
        err_d = err_q | g_ill;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == (AW+1)'(1))
          state_d = DONE;
        else
          ptr_d = dir_q ? (ptr_q - 1'b1) : (ptr_q + 1'b1);
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE && prog_we)
      mem_q[prog_addr] <= prog_data;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign out_data  = r_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rev_gate_sequencer.sv
// Scoreboard bench for rev_gate_sequencer: driver queues expected results,
// a negedge monitor checks data, err and latency when out_valid rises.
module tb_rev_gate_sequencer;

  logic       clk = 0;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       len_we;
  logic [4:0] len_data;
  logic       dir;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       err;

  rev_gate_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .len_we(len_we), .len_data(len_data), .dir(dir),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       e;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc = 0;
  logic prev_ov = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (in_valid && in_ready && !rst) acc = cyc;
  end

  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", int'(out_data), int'(e.data));
        chk("err", int'(err), int'(e.e));
        chk("latency", cyc - acc + 1, e.lat);
      end
    end
    prev_ov = out_valid;
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 0;
  endtask

  task automatic set_len(input logic [4:0] l);
    @(negedge clk);
    len_we = 1; len_data = l;
    @(negedge clk);
    len_we = 0;
  endtask

  task automatic run(input logic [3:0] d, input logic dr,
                     input logic [3:0] ed, input logic ee,
                     input int el, input int hold,
                     input logic w, input logic [7:0] wd);
    int n;
    exp_q.push_back('{ed, ee, el});
    @(negedge clk);
    in_data = d; dir = dr; in_valid = 1;
    prog_we = w; prog_addr = 4'd0; prog_data = wd;
    @(negedge clk);
    in_valid = 0; prog_we = 0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout: out_valid 0 after %0d cycles", n);
    end else begin
      for (int i = 0; i < hold; i++) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(ed));
        chk("hold_in_ready", int'(in_ready), 0);
        prog_we = (i == 1); prog_addr = 4'd0; prog_data = 8'h00;
        @(negedge clk);
      end
      prog_we = 0;
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
    end
  endtask

  initial begin
    rst = 1; prog_we = 0; prog_addr = 0; prog_data = 0;
    len_we = 0; len_data = 0; dir = 0; in_valid = 0;
    in_data = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_r", int'(out_data), 0);
    rst = 0;

    // fan-out CNOT, L=1
    wr(4'd0, 8'hC0);
    set_len(5'd1);
    run(4'b0001, 0, 4'b1111, 0, 2, 0, 0, 0);
    run(4'b0110, 0, 4'b0110, 0, 2, 0, 0, 0);

    // NOT/CNOT/Toffoli forward then reverse
    wr(4'd0, 8'h10);
    wr(4'd1, 8'h64);
    wr(4'd2, 8'hB6);
    set_len(5'd3);
    run(4'b0000, 0, 4'b1110, 0, 4, 0, 0, 0);
    run(4'b1110, 1, 4'b0000, 0, 4, 0, 0, 0);

    // L=0 passthrough
    set_len(5'd0);
    run(4'hA, 0, 4'hA, 0, 1, 0, 0, 0);

    // L clamped to 16: 15x NOT t0 then NOT t3
    for (int i = 0; i < 15; i++) wr(4'(i), 8'h00);
    wr(4'd15, 8'h30);
    set_len(5'd20);
    run(4'b0000, 0, 4'b1001, 0, 17, 0, 0, 0);
    run(4'b0000, 1, 4'b1001, 0, 17, 0, 0, 0);

    // illegal CNOT t=c=2 then NOT t0
    wr(4'd0, 8'h68);
    wr(4'd1, 8'h00);
    set_len(5'd2);
    run(4'b0101, 0, 4'b0100, 1, 3, 0, 0, 0);
    set_len(5'd0);
    run(4'h3, 0, 4'h3, 0, 1, 0, 0, 0);

    // hold in DONE with ignored write, then rerun
    wr(4'd0, 8'hC0);
    set_len(5'd1);
    run(4'b0001, 0, 4'b1111, 0, 2, 5, 0, 0);
    run(4'b0001, 0, 4'b1111, 0, 2, 0, 0, 0);

    // write committed together with accept
    run(4'b0001, 0, 4'b0000, 0, 2, 0, 1, 8'h00);

    // reset in 2nd RUN cycle
    wr(4'd0, 8'h68);
    wr(4'd1, 8'h00);
    wr(4'd2, 8'h00);
    wr(4'd3, 8'h00);
    set_len(5'd4);
    @(negedge clk);
    in_data = 4'h0; dir = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    chk("mid_err", int'(err), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rr_in_ready", int'(in_ready), 1);
    chk("rr_out_valid", int'(out_valid), 0);
    chk("rr_busy", int'(busy), 0);
    chk("rr_err", int'(err), 0);
    run(4'h7, 0, 4'h7, 0, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rev_gate_sequencer.md
Name: rev_gate_sequencer

Overview:
- Sequences a stored program of self-inverse reversible gates (NOT, CNOT, Toffoli, fan-out CNOT) over a 4-bit working register, one gate per cycle.
- Runs forward (entries 0..L-1) or reverse (L-1..0), so the same program both computes and uncomputes.
- Sits between the microprocessor control path and the reversible ALU gate primitives.
- Provides valid/ready handshakes on operand in and result out.

Parameters:
DEPTH, 16, number of program entries.
AW, 4, program address width; must equal clog2(DEPTH).

Ports:
clk  input  1  clock, all logic rising-edge.
rst  input  1  synchronous reset, active-high.
prog_we  input  1  write program entry; honoured only in IDLE.
prog_addr  input  AW  program entry address.
prog_data  input  8  entry: [7:6] op, [5:4] target, [3:2] ctrl_a, [1:0] ctrl_b.
len_we  input  1  write program length; honoured only in IDLE.
len_data  input  AW+1  program length L; values > DEPTH are stored as DEPTH.
dir  input  1  sampled on accept: 0 forward, 1 reverse.
in_valid  input  1  operand valid.
in_data  input  4  operand.
in_ready  output  1  high in IDLE only.
out_valid  output  1  high in DONE only.
out_data  output  4  working register; meaningful when out_valid.
out_ready  input  1  result consumed.
busy  output  1  high in RUN.
err  output  1  sticky illegal-gate flag; cleared on accept or by rst.

Behaviour:
- Reset state: IDLE, working register 0, L=0, err=0, in_ready=1, out_valid=0, busy=0. Program memory is not reset.
- Gate semantics on register r (op code, gate):
  - 00 NOT: r[target] ^= 1.
  - 01 CNOT: r[target] ^= r[ctrl_a].
  - 10 Toffoli: r[target] ^= r[ctrl_a] & r[ctrl_b].
  - 11 fan-out CNOT: every bit other than ctrl_a toggles by r[ctrl_a]. target and ctrl_b are ignored.
- Illegal gates leave r unchanged for that step and set err:
  - CNOT with target==ctrl_a.
  - Toffoli with target equal to either control, or ctrl_a==ctrl_b.
- All gates are self-inverse. For any legal program, reverse execution of forward output returns the original operand.
- IDLE:
  - in_valid & in_ready accepts: r<=in_data, dir latched, err<=0.
  - ptr<=0 (forward) or L-1 (reverse).
  - Next state is RUN if L>0, else DONE.
- RUN:
  - Each cycle applies entry[ptr] to r. ptr increments (forward) or decrements (reverse).
  - After the L-th gate, the next state is DONE.
  - Latency: accept edge to out_valid is L+1 cycles; L=0 gives 1 cycle with out_data=in_data.
- DONE:
  - out_valid=1, out_data=r, held stable while out_ready=0.
  - out_valid & out_ready moves to IDLE. No same-cycle re-accept.
- prog_we/len_we outside IDLE are ignored. Simultaneous prog_we and accept in IDLE: the write commits, and the run uses the updated memory.
- Reads are combinational from a register array, addressed by ptr.
- rst asserted in any state, including mid-RUN, forces the reset state next cycle; the partial result is discarded.
- ptr never wraps: a forward run stops at L-1 and a reverse run stops at 0.

Test Plan:
- Program entry0 = fan-out CNOT ctrl_a=0 (0xC0), L=1, forward, in_data=4'b0001 -> out_data=4'b1111 two cycles after accept; in_data=4'b0110 -> out 4'b0110.
- Program {NOT t=1, CNOT t=2 c=1, Toffoli t=3 c=1,2}, L=3, forward in 4'b0000 -> 4'b1110, out_valid 4 cycles after accept; reverse run of 4'b1110 -> 4'b0000.
- L=0 and in_data=4'hA -> out_data=4'hA after 1 cycle; len_data=20 with DEPTH=16 -> run takes 16 gate cycles.
- CNOT t=2 c=2 in a 2-entry program -> err=1 at DONE, that step leaves r unchanged; next accept clears err.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, prog_we ignored (memory readback unchanged).
- Assert rst at the 2nd RUN cycle of an L=4 run -> next cycle IDLE, in_ready=1, out_valid=0, busy=0, err=0, L=0.
